// File: rtl/path_delay_pkg.sv
// Shared types and constants for the path delay meter.
// Optional averaging build: define PDM_AVERAGE_EN.
package path_delay_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_DONE
   } pdm_state_t;

   localparam int PDM_SYNC_STAGES = 2;
   localparam int PDM_MIN_COUNT   = 2;

endpackage

// File: rtl/path_sync.sv
// Two-flop synchronizer for the returning chain output.
// Keep and placement constraints attach to sync_q.
module path_sync
   import path_delay_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   (* keep = 1 *) logic [PDM_SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[PDM_SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[PDM_SYNC_STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launch/capture controller timing one delay-chain path in clk cycles.
// Define PDM_AVERAGE_EN to average 2^AVG_LOG2 runs per start.
module path_delay_meter
   import path_delay_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 1000,
   parameter int SETTLE   = 16,
   parameter int AVG_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             pathInput,
   input  logic             pathResult,
   output logic             busy,
   output logic             measValid,
   input  logic             measReady,
   output logic [CNT_W-1:0] measCount,
   output logic             measTimeout
);

   localparam int SET_W = $clog2(SETTLE);

   if (TIMEOUT < 3 || (TIMEOUT >> CNT_W) != 0 ||
       SETTLE < 3 || AVG_LOG2 < 0) begin : g_bad_cfg
      $error("path_delay_meter: bad parameters");
   end

   pdm_state_t       state_q;
   logic [SET_W-1:0] settle_q;
   logic [CNT_W-1:0] cnt_q;
   logic             base_q;
   logic             path_in_q;
   logic             busy_q;
   logic             valid_q;
   logic [CNT_W-1:0] count_q;
   logic             tmo_q;
   logic             res_sync;
   logic             arrived;

   path_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (pathResult),
      .q_o   (res_sync)
   );

   assign arrived = (res_sync != base_q);

`ifdef PDM_AVERAGE_EN
   localparam int ACC_W = CNT_W + AVG_LOG2;

   logic [ACC_W-1:0]  acc_q;
   logic [AVG_LOG2:0] run_q;
   logic [ACC_W-1:0]  acc_sum;
   logic [ACC_W-1:0]  acc_shr;
   logic              last_run;

   always_comb begin
      acc_sum  = acc_q + ACC_W'(cnt_q);
      acc_shr  = acc_sum >> AVG_LOG2;
      last_run = (run_q == (AVG_LOG2+1)'((1 << AVG_LOG2) - 1));
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         settle_q  <= '0;
         cnt_q     <= '0;
         base_q    <= 1'b0;
         path_in_q <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         count_q   <= '0;
         tmo_q     <= 1'b0;
`ifdef PDM_AVERAGE_EN
         acc_q     <= '0;
         run_q     <= '0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q  <= ST_SETTLE;
                  settle_q <= '0;
                  busy_q   <= 1'b1;
`ifdef PDM_AVERAGE_EN
                  acc_q    <= '0;
                  run_q    <= '0;
`endif
               end
            end
            ST_SETTLE: begin
               if (settle_q == SET_W'(SETTLE - 1)) begin
                  base_q  <= res_sync;
                  state_q <= ST_LAUNCH;
               end else begin
                  settle_q <= settle_q + SET_W'(1);
               end
            end
            ST_LAUNCH: begin
               path_in_q <= ~path_in_q;
               cnt_q     <= '0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (arrived) begin
`ifdef PDM_AVERAGE_EN
                  acc_q <= acc_sum;
                  if (last_run) begin
                     count_q <= CNT_W'(acc_shr);
                     tmo_q   <= 1'b0;
                     valid_q <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     run_q    <= run_q + (AVG_LOG2+1)'(1);
                     settle_q <= '0;
                     state_q  <= ST_SETTLE;
                  end
`else
                  count_q <= cnt_q;
                  tmo_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
`endif
               end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                  // remaining averaging runs are abandoned here too
                  count_q <= CNT_W'(TIMEOUT);
                  tmo_q   <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (measReady) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign pathInput   = path_in_q;
   assign busy        = busy_q;
   assign measValid   = valid_q;
   assign measCount   = count_q;
   assign measTimeout = tmo_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed vector bench for path_delay_meter (default build).
module tb_path_delay_meter;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 20;
   localparam int SETTLE  = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             pathInput;
   logic             pathResult;
   logic             busy;
   logic             measValid;
   logic             measReady = 1'b0;
   logic [CNT_W-1:0] measCount;
   logic             measTimeout;

   int total = 0;
   int bad = 0;

   int          mode = 0;
   int          dly = 0;
   logic [7:0]  dl = '0;

   always #5 clk = ~clk;

   always @(posedge clk) dl <= {dl[6:0], pathInput};

   always_comb begin
      pathResult = 1'b0;
      if (mode == 0) begin
         if (dly == 0) pathResult = pathInput;
         else pathResult = dl[dly-1];
      end
   end

   path_delay_meter #(
      .CNT_W    (CNT_W),
      .TIMEOUT  (TIMEOUT),
      .SETTLE   (SETTLE),
      .AVG_LOG2 (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pathInput   (pathInput),
      .pathResult  (pathResult),
      .busy        (busy),
      .measValid   (measValid),
      .measReady   (measReady),
      .measCount   (measCount),
      .measTimeout (measTimeout)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // pulse start, return cycles from the sampling edge to measValid
   task automatic launch(output int lat);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      while (!measValid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic accept(input string name);
      measReady = 1'b1;
      @(posedge clk);
      #1;
      measReady = 1'b0;
      chk({name, "_valid_drop"}, int'(measValid), 0);
      chk({name, "_busy_drop"}, int'(busy), 0);
   endtask

   typedef struct {
      int mode;
      int delay;
      int exp_cnt;
      int exp_to;
      int exp_pin;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int lat;
      logic [CNT_W-1:0] held;
      int stable;
      int launched;
      logic pin0;

      vecs[0] = '{0, 0, 2, 0, 1};
      vecs[1] = '{0, 0, 2, 0, 0};
      vecs[2] = '{0, 5, 7, 0, 1};
      vecs[3] = '{0, 5, 7, 0, 0};
      vecs[4] = '{0, 1, 3, 0, 1};
      vecs[5] = '{0, 3, 5, 0, 0};
      vecs[6] = '{1, 0, TIMEOUT, 1, 1};

      #12;
      chk("rst_pin", int'(pathInput), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(measValid), 0);
      chk("rst_count", int'(measCount), 0);
      chk("rst_tmo", int'(measTimeout), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      for (int v = 0; v < 7; v++) begin
         mode = vecs[v].mode;
         dly  = vecs[v].delay;
         idle(12);
         launch(lat);
         chk($sformatf("v%0d_latency", v), lat,
             SETTLE + 2 + vecs[v].exp_cnt);
         chk($sformatf("v%0d_count", v), int'(measCount), vecs[v].exp_cnt);
         chk($sformatf("v%0d_timeout", v), int'(measTimeout), vecs[v].exp_to);
         chk($sformatf("v%0d_pin", v), int'(pathInput), vecs[v].exp_pin);
         chk($sformatf("v%0d_busy", v), int'(busy), 1);
         accept($sformatf("v%0d", v));
      end

      // backpressure with ignored start pulses
      mode = 0;
      dly  = 0;
      idle(12);
      launch(lat);
      chk("bp_count", int'(measCount), 2);
      held = measCount;
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         start = (i % 3 == 0);
         @(posedge clk);
         #1;
         if (!measValid || measCount != held) stable = 0;
      end
      start = 1'b0;
      chk("bp_stable", stable, 1);
      pin0 = pathInput;
      accept("bp");
      launched = 0;
      for (int i = 0; i < SETTLE + 12; i++) begin
         @(posedge clk);
         #1;
         if (busy || measValid || pathInput != pin0) launched = 1;
      end
      chk("bp_no_relaunch", launched, 0);

      // reset in WAIT, then a normal measurement
      mode = 1;
      idle(4);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      idle(SETTLE + 5);
      chk("mid_busy", int'(busy), 1);
      chk("mid_pin", int'(pathInput), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pin", int'(pathInput), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_valid", int'(measValid), 0);
      chk("arst_count", int'(measCount), 0);
      chk("arst_tmo", int'(measTimeout), 0);
      @(negedge clk);
      rst_n = 1'b1;
      mode = 0;
      dly  = 0;
      idle(12);
      launch(lat);
      chk("post_rst_latency", lat, SETTLE + 4);
      chk("post_rst_count", int'(measCount), 2);
      chk("post_rst_tmo", int'(measTimeout), 0);
      chk("post_rst_pin", int'(pathInput), 1);
      accept("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
